vsb_rr_burst_arbiter: RTL and testbench
=======================================

Name: vsb_rr_burst_arbiter

Overview:
Parametrised successor to the VSB round-robin channel arbiter. Arbitrates NUM_CH request channels onto one internal VSB write/read stream, with valid/ready handshaking on both sides. Adds multi-beat burst locking with a configurable burst cap, output backpressure, and a selectable fixed-priority mode. Sits between the per-channel VSB masters and the internal VSB bus register stage.

Parameters:
NUM_CH, 4, number of request channels (≥2)
DATA_W, 32, data width per channel
ADDR_W, 16, address width per channel
MAX_BURST, 4, max beats per grant before forced re-arbitration (≥1)
ARB_MODE, 0, 0 = round robin, 1 = fixed priority (lowest index wins)
CH_W, $clog2(NUM_CH), channel index width (derived)

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high
req_valid  in  NUM_CH  per-channel beat valid
req_ready  out  NUM_CH  per-channel beat accept
req_wr  in  NUM_CH  per-channel write flag
req_last  in  NUM_CH  per-channel last beat of burst
req_data  in  NUM_CH*DATA_W  flattened, channel i at [i*DATA_W +: DATA_W]
req_addr  in  NUM_CH*ADDR_W  flattened, channel i at [i*ADDR_W +: ADDR_W]
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  granted beat data
out_addr  out  ADDR_W  granted beat address
out_wr  out  1  granted beat write flag
out_ch  out  CH_W  source channel of out beat
out_last  out  1  burst end (req_last or cap reached)
busy  out  1  high while in GRANT state

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: req_ready=0, out_valid=0, out_data/addr/wr/ch/last=0, busy=0, state=IDLE, beat counter=0, RR pointer=NUM_CH-1 (channel 0 has first priority).
- States: IDLE, GRANT.
- IDLE: if any req_valid, select winner: ARB_MODE=0 → first set bit scanning pointer+1, pointer+2, … modulo NUM_CH; ARB_MODE=1 → lowest set index. Register grant, go GRANT next cycle. No req_valid → stay IDLE.
- GRANT: req_ready[g] = !out_valid | out_ready; all other req_ready=0. Beat = req_valid[g] & req_ready[g].
- On beat: out register loads data/addr/wr of channel g, out_ch=g, out_valid=1, counter+1; out_last = req_last[g] | (counter == MAX_BURST-1).
- Output register holds contents stable while out_valid & !out_ready; clears out_valid on out_ready with no new beat.
- Burst end (beat with out_last=1): counter=0, pointer=g, state→IDLE. One-cycle arbitration bubble between grants.
- Grant holder dropping req_valid mid-burst: grant stays locked, no timeout; masters must complete bursts.
- Latency: req_valid at cycle 0 (IDLE) → req_ready cycle 1 → out_valid cycle 2. Sustained throughput within a burst: 1 beat/cycle with out_ready=1.
- Burst longer than MAX_BURST: split; remaining beats re-arbitrate like a new request (out_last marks each split).
- Simultaneous requests in IDLE: exactly one grant; no two req_ready bits ever high together.
- MAX_BURST=1: every beat is a separate grant.
- Reset mid-burst: all state/outputs to reset values the following edge; any pending out beat discarded.

Test Plan:
- Reset: assert reset 2 cycles with all req_valid=1 → out_valid=0, req_ready=0, busy=0, out_ch=0.
- RR fairness: ARB_MODE=0, ch0..3 req_valid=1, req_last=1 always, out_ready=1 → out_ch sequence 0,1,2,3,0,1, one beat per 2 cycles.
- Burst cap: MAX_BURST=4, ch1 sends 6 beats (last on 6th), ch2 requesting → ch1 beats 1–4 (out_last on 4th), ch2 burst, then ch1 beats 5–6.
- Backpressure: mid-burst drop out_ready for 3 cycles → out_data/out_addr/out_ch unchanged, req_ready[g]=0, all beats delivered once in order.
- Fixed priority: ARB_MODE=1, ch0 and ch3 continuously requesting single beats → out_ch always 0; ch3 granted only after ch0 deasserts.
- Reset mid-burst: reset during beat 2 of ch2 burst → next cycle out_valid=0, busy=0; afterwards ch0 wins first with all requesting.

Source files
------------

// File: rtl/vsb_rr_burst_arbiter.sv
// vsb_rr_burst_arbiter: round-robin/fixed-priority VSB channel arbiter with capped burst locking and output backpressure
module vsb_rr_burst_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int MAX_BURST = 4,
  parameter int ARB_MODE  = 0,
  parameter int CH_W      = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          req_wr,
  input  logic [NUM_CH-1:0]          req_last,
  input  logic [NUM_CH*DATA_W-1:0]   req_data,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic                       out_wr,
  output logic [CH_W-1:0]            out_ch,
  output logic                       out_last,
  output logic                       busy
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e            state_q;
  logic [CH_W-1:0]   grant_q, ptr_q, base, win;
  logic [CNT_W-1:0]  cnt_q;
  logic              beat, last;
  // fixed priority is round robin with the scan always starting just past the top channel
  assign base = (ARB_MODE != 0) ? CH_W'(NUM_CH - 1) : ptr_q;
  always_comb begin
    win = '0;
    for (int k = NUM_CH; k >= 1; k--)
      if (req_valid[(int'(base) + k) % NUM_CH]) win = CH_W'((int'(base) + k) % NUM_CH);
  end
  assign req_ready = (state_q == GRANT) ? NUM_CH'(!out_valid || out_ready) << grant_q : '0;
  assign beat      = |(req_ready & req_valid);
  assign last      = req_last[grant_q] || (cnt_q == CNT_W'(MAX_BURST - 1));
  assign busy      = state_q == GRANT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= CH_W'(NUM_CH - 1);
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_wr    <= 1'b0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state_q == IDLE && |req_valid) begin
        state_q <= GRANT;
        grant_q <= win;
      end
      if (beat) begin
        out_valid <= 1'b1;
        out_data  <= req_data[grant_q*DATA_W +: DATA_W];
        out_addr  <= req_addr[grant_q*ADDR_W +: ADDR_W];
        out_wr    <= req_wr[grant_q];
        out_ch    <= grant_q;
        out_last  <= last;
        cnt_q     <= last ? '0 : cnt_q + CNT_W'(1);
        if (last) begin
          ptr_q   <= grant_q;
          state_q <= IDLE;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vsb_rr_burst_arbiter.sv
// tb_vsb_rr_burst_arbiter: round-robin and fixed-priority instances checked every cycle against a behavioural model
module tb_vsb_rr_burst_arbiter;
  localparam int MODE [2] = '{0, 1};
  localparam int MAXB [2] = '{4, 2};
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] req_valid = '0, req_wr = '0, req_last = '0;
  logic out_ready = 1'b0;
  logic [127:0] req_data = '0;
  logic [63:0] req_addr = '0;
  logic [3:0] rdy [2];
  logic ov [2], owr [2], olast [2], bsy [2];
  logic [31:0] od [2];
  logic [15:0] oa [2];
  logic [1:0] och [2];
  int checks = 0, failures = 0;
  int hold [2] = '{-1, -1};
  int ptr [2] = '{3, 3};
  int cnt [2] = '{0, 0};
  int mch [2] = '{0, 0};
  logic mov [2] = '{1'b0, 1'b0};
  logic mwr [2] = '{1'b0, 1'b0};
  logic mlast [2] = '{1'b0, 1'b0};
  logic [31:0] md [2] = '{32'd0, 32'd0};
  logic [15:0] ma [2] = '{16'd0, 16'd0};
  int idx [4], rem [4];
  int log0 [$], log1 [$];

  always #5 clk = ~clk;

  vsb_rr_burst_arbiter #(.NUM_CH(4), .DATA_W(32), .ADDR_W(16), .MAX_BURST(4), .ARB_MODE(0)) u_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]), .req_wr(req_wr),
    .req_last(req_last), .req_data(req_data), .req_addr(req_addr), .out_valid(ov[0]),
    .out_ready(out_ready), .out_data(od[0]), .out_addr(oa[0]), .out_wr(owr[0]),
    .out_ch(och[0]), .out_last(olast[0]), .busy(bsy[0]));

  vsb_rr_burst_arbiter #(.NUM_CH(4), .DATA_W(32), .ADDR_W(16), .MAX_BURST(2), .ARB_MODE(1)) u_fp (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]), .req_wr(req_wr),
    .req_last(req_last), .req_data(req_data), .req_addr(req_addr), .out_valid(ov[1]),
    .out_ready(out_ready), .out_data(od[1]), .out_addr(oa[1]), .out_wr(owr[1]),
    .out_ch(och[1]), .out_last(olast[1]), .busy(bsy[1]));

  function automatic int mk(int c, int i, int l);
    return (c * 256 + i) * 2 + l;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int pick(int m);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (MODE[m] != 0) ? k - 1 : (ptr[m] + k) % 4;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  // advance the model across the coming rising edge using the inputs now on the bus
  task automatic adv;
    for (int m = 0; m < 2; m++) begin
      int h;
      logic bt;
      if (reset) begin
        hold[m] = -1; ptr[m] = 3; cnt[m] = 0; mov[m] = 1'b0; md[m] = '0;
        ma[m] = '0; mwr[m] = 1'b0; mch[m] = 0; mlast[m] = 1'b0;
      end else begin
        h = hold[m];
        bt = (h >= 0) ? (req_valid[h] && (!mov[m] || out_ready)) : 1'b0;
        if (h < 0 && req_valid != 4'b0) hold[m] = pick(m);
        if (bt) begin
          mov[m] = 1'b1;
          md[m] = req_data[h*32 +: 32];
          ma[m] = req_addr[h*16 +: 16];
          mwr[m] = req_wr[h];
          mch[m] = h;
          cnt[m]++;
          mlast[m] = req_last[h] || cnt[m] == MAXB[m];
          if (mlast[m]) begin
            ptr[m] = h; hold[m] = -1; cnt[m] = 0;
          end
        end else if (out_ready) begin
          mov[m] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    logic [3:0] er;
    forever begin
      @(negedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        er = (hold[m] >= 0 && (!mov[m] || out_ready)) ? 4'(1 << hold[m]) : 4'b0;
        chk($sformatf("req_ready[%0d]", m), 64'(rdy[m]), 64'(er));
        chk($sformatf("onehot[%0d]", m), 64'($onehot0(rdy[m])), 64'd1);
        chk($sformatf("out_valid[%0d]", m), 64'(ov[m]), 64'(mov[m]));
        chk($sformatf("busy[%0d]", m), 64'(bsy[m]), 64'(hold[m] >= 0));
        chk($sformatf("out_ch[%0d]", m), 64'(och[m]), 64'(mch[m]));
        chk($sformatf("out_last[%0d]", m), 64'(olast[m]), 64'(mlast[m]));
        chk($sformatf("out_data[%0d]", m), 64'(od[m]), 64'(md[m]));
        chk($sformatf("out_addr[%0d]", m), 64'(oa[m]), 64'(ma[m]));
        chk($sformatf("out_wr[%0d]", m), 64'(owr[m]), 64'(mwr[m]));
      end
      if (ov[0] && out_ready) log0.push_back(int'(od[0]) * 2 + int'(olast[0]));
      if (ov[1] && out_ready) log1.push_back(int'(od[1]) * 2 + int'(olast[1]));
      adv();
    end
  end

  task automatic step(input logic r, input logic [3:0] v, input logic [3:0] l, input logic o);
    @(negedge clk);
    reset = r; req_valid = v; req_last = l; out_ready = o; req_wr = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      req_data[c*32 +: 32] = 32'(c * 256 + idx[c]);
      req_addr[c*16 +: 16] = 16'(c * 4096 + idx[c]);
    end
    #2;
    if (!r) for (int c = 0; c < 4; c++) if (v[c] && rdy[0][c]) begin idx[c]++; rem[c]--; end
  endtask

  task automatic step_src(input logic r, input logic o);
    logic [3:0] v, l;
    for (int c = 0; c < 4; c++) begin
      v[c] = rem[c] > 0;
      l[c] = rem[c] == 1;
    end
    step(r, v, l, o);
  endtask

  task automatic init_src(input int r0, input int r1, input int r2, input int r3);
    rem[0] = r0; rem[1] = r1; rem[2] = r2; rem[3] = r3;
    for (int c = 0; c < 4; c++) idx[c] = 0;
    log0.delete();
    log1.delete();
  endtask

  task automatic do_reset;
    step(1'b1, 4'h0, 4'h0, 1'b1);
    step(1'b1, 4'h0, 4'h0, 1'b1);
  endtask

  function automatic int at(input int q [$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int e [8];
    logic [31:0] d0;
    logic [15:0] a0;
    init_src(0, 0, 0, 0);
    step(1'b1, 4'hf, 4'hf, 1'b1);
    step(1'b1, 4'hf, 4'hf, 1'b1);
    for (int m = 0; m < 2; m++) begin
      chk("rst_out_valid", 64'(ov[m]), 64'd0);
      chk("rst_req_ready", 64'(rdy[m]), 64'd0);
      chk("rst_busy", 64'(bsy[m]), 64'd0);
      chk("rst_out_ch", 64'(och[m]), 64'd0);
    end
    init_src(0, 0, 0, 0);
    for (int k = 0; k < 14; k++) step(1'b0, 4'hf, 4'hf, 1'b1);
    e = '{mk(0,0,1), mk(1,0,1), mk(2,0,1), mk(3,0,1), mk(0,1,1), mk(1,1,1), 0, 0};
    chk("rr_count", 64'(log0.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_seq%0d", i), 64'(at(log0, i)), 64'(e[i]));
    chk("fp_count", 64'(log1.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("fp_ch%0d", i), 64'(at(log1, i) >>> 9), 64'd0);
    do_reset();
    init_src(0, 6, 2, 0);
    for (int k = 0; k < 14; k++) step_src(1'b0, 1'b1);
    e = '{mk(1,0,0), mk(1,1,0), mk(1,2,0), mk(1,3,1), mk(2,0,0), mk(2,1,1), mk(1,4,0), mk(1,5,1)};
    chk("cap_count", 64'(log0.size()), 64'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("cap_seq%0d", i), 64'(at(log0, i)), 64'(e[i]));
    do_reset();
    init_src(4, 0, 0, 0);
    d0 = '0;
    a0 = '0;
    for (int k = 0; k < 12; k++) begin
      step_src(1'b0, !(k >= 4 && k <= 6));
      if (k == 4) begin
        d0 = od[0];
        a0 = oa[0];
        chk("bp_valid", 64'(ov[0]), 64'd1);
        chk("bp_data", 64'(d0), 64'(32'd2));
      end
      if (k >= 4 && k <= 6) chk($sformatf("bp_ready%0d", k), 64'(rdy[0]), 64'd0);
      if (k == 5 || k == 6) begin
        chk($sformatf("bp_hold_data%0d", k), 64'(od[0]), 64'(d0));
        chk($sformatf("bp_hold_addr%0d", k), 64'(oa[0]), 64'(a0));
        chk($sformatf("bp_hold_ch%0d", k), 64'(och[0]), 64'd0);
      end
    end
    e = '{mk(0,0,0), mk(0,1,0), mk(0,2,0), mk(0,3,1), 0, 0, 0, 0};
    chk("bp_count", 64'(log0.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_seq%0d", i), 64'(at(log0, i)), 64'(e[i]));
    do_reset();
    init_src(0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(1'b0, 4'b1001, 4'hf, 1'b1);
    chk("fix_count", 64'(log1.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("fix_ch%0d", i), 64'(at(log1, i) >>> 9), 64'd0);
    for (int k = 0; k < 6; k++) step(1'b0, 4'b1000, 4'hf, 1'b1);
    chk("fix_count2", 64'(log1.size()), 64'd7);
    chk("fix_last0", 64'(at(log1, 4) >>> 9), 64'd0);
    chk("fix_ch3", 64'(at(log1, 5) >>> 9), 64'd3);
    do_reset();
    init_src(0, 0, 4, 0);
    step_src(1'b0, 1'b1);
    step_src(1'b0, 1'b1);
    step_src(1'b1, 1'b1);
    init_src(1, 1, 1, 1);
    step_src(1'b0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      chk("mid_rst_valid", 64'(ov[m]), 64'd0);
      chk("mid_rst_busy", 64'(bsy[m]), 64'd0);
    end
    log0.delete();
    for (int k = 0; k < 9; k++) step_src(1'b0, 1'b1);
    chk("mid_rst_first", 64'(at(log0, 0)), 64'(mk(0,0,1)));
    chk("mid_rst_second", 64'(at(log0, 1)), 64'(mk(1,0,1)));
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = $urandom_range(0, 199) == 0;
      req_valid = 4'($urandom);
      req_last = 4'($urandom);
      req_wr = 4'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      req_data = {$urandom, $urandom, $urandom, $urandom};
      req_addr = {$urandom, $urandom};
    end
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
